// File: rtl/elevator_pkg.sv
// Shared types for the four-floor elevator controller: FSM states, floor index
// and a one-hot floor helper.
package elevator_pkg;

    localparam int NUM_FLOORS = 4;

    typedef logic [1:0]            floor_t;
    typedef logic [NUM_FLOORS-1:0] floor_mask_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        DOOR  = 3'd3,
        ESTOP = 3'd4
    } state_t;

    function automatic floor_mask_t floor_bit(input floor_t f);
        floor_mask_t m;
        m    = '0;
        m[f] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/elevator_req_sched.sv
// Combinational request scan: where pending calls lie relative to a floor,
// both absolutely (above/below) and relative to the travel direction.
module elevator_req_sched
    import elevator_pkg::*;
(
    input  floor_mask_t pending_next,
    input  floor_t      floor,
    input  logic        dir_up,
    output logic        has_here,
    output logic        has_above,
    output logic        has_below,
    output logic        has_ahead,
    output logic        has_behind
);

    always_comb begin
        has_here  = pending_next[floor];
        has_above = 1'b0;
        has_below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (i > int'(floor)) has_above = has_above | pending_next[i];
            if (i < int'(floor)) has_below = has_below | pending_next[i];
        end
        has_ahead  = dir_up ? has_above : has_below;
        has_behind = dir_up ? has_below : has_above;
    end

endmodule

// File: rtl/elevator.sv
// Four-floor SCAN elevator controller with emergency-stop override.
// Optional door dwell state is enabled by defining ELEVATOR_DOOR_DWELL_EN.
module elevator
    import elevator_pkg::*;
#(
    parameter int FLOOR_TRAVEL_CYCLES = 1,
    parameter int DOOR_DWELL_CYCLES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  floor_mask_t floor_req,
    input  logic        emergency_stop,
    output logic        move_up,
    output logic        move_down,
    output logic        motor_stop,
    output floor_t      current_floor,
    output state_t      dbg_state
);

    localparam int TW = (FLOOR_TRAVEL_CYCLES > 1) ? $clog2(FLOOR_TRAVEL_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TRAVEL_CYCLES - 1);

    if (FLOOR_TRAVEL_CYCLES < 1 || DOOR_DWELL_CYCLES < 1) begin : g_bad_param
        $error("elevator: travel and dwell cycle counts must be at least 1");
    end

    state_t      state, state_nx;
    floor_t      floor_nx, arrive_floor;
    floor_mask_t pending, pending_next, pending_nx;
    logic        dir_up, dir_nx;
    logic [TW-1:0] travel_cnt, travel_nx;
    logic        arrive;
    logic        has_here, has_above, has_below, has_ahead, has_behind;

`ifdef ELEVATOR_DOOR_DWELL_EN
    localparam int DW = (DOOR_DWELL_CYCLES > 1) ? $clog2(DOOR_DWELL_CYCLES) : 1;
    localparam logic [DW-1:0] DOOR_LAST = DW'(DOOR_DWELL_CYCLES - 1);
    logic [DW-1:0] door_cnt, door_nx;
`endif

    assign dbg_state = state;

    // Requests freeze during ESTOP; scheduling always looks at the arrival floor when moving.
    always_comb begin
        pending_next = (state == ESTOP) ? pending : (pending | floor_req);
        arrive       = 1'b0;
        arrive_floor = current_floor;
        if ((state == UP || state == DOWN) && travel_cnt == TRAVEL_LAST) begin
            arrive       = 1'b1;
            arrive_floor = (state == UP) ? current_floor + floor_t'(1)
                                         : current_floor - floor_t'(1);
        end
    end

    elevator_req_sched u_sched (
        .pending_next (pending_next),
        .floor        (arrive_floor),
        .dir_up       (dir_up),
        .has_here     (has_here),
        .has_above    (has_above),
        .has_below    (has_below),
        .has_ahead    (has_ahead),
        .has_behind   (has_behind)
    );

    always_comb begin
        state_nx   = state;
        floor_nx   = current_floor;
        pending_nx = pending_next;
        dir_nx     = dir_up;
        travel_nx  = travel_cnt;
`ifdef ELEVATOR_DOOR_DWELL_EN
        door_nx    = door_cnt;
`endif
        if (emergency_stop) begin
            state_nx  = ESTOP;
            travel_nx = '0;
`ifdef ELEVATOR_DOOR_DWELL_EN
            door_nx   = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (has_here) begin
                        pending_nx = pending_next & ~floor_bit(current_floor);
`ifdef ELEVATOR_DOOR_DWELL_EN
                        state_nx   = DOOR;
`endif
                    end else if (has_ahead) begin
                        state_nx = dir_up ? UP : DOWN;
                    end else if (has_behind) begin
                        state_nx = dir_up ? DOWN : UP;
                        dir_nx   = ~dir_up;
                    end
                end
                UP, DOWN: begin
                    if (arrive) begin
                        floor_nx  = arrive_floor;
                        travel_nx = '0;
                        if (has_here) begin
                            pending_nx = pending_next & ~floor_bit(arrive_floor);
`ifdef ELEVATOR_DOOR_DWELL_EN
                            state_nx   = DOOR;
`else
                            state_nx   = IDLE;
`endif
                        end else if (!((state == UP) ? has_above : has_below)) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        travel_nx = travel_cnt + TW'(1);
                    end
                end
                DOOR: begin
`ifdef ELEVATOR_DOOR_DWELL_EN
                    pending_nx = pending_next & ~floor_bit(current_floor);
                    if (door_cnt == DOOR_LAST) begin
                        state_nx = IDLE;
                        door_nx  = '0;
                    end else begin
                        door_nx = door_cnt + DW'(1);
                    end
`else
                    state_nx = IDLE;
`endif
                end
                ESTOP:   state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            current_floor <= '0;
            pending       <= '0;
            dir_up        <= 1'b1;
            travel_cnt    <= '0;
            move_up       <= 1'b0;
            move_down     <= 1'b0;
            motor_stop    <= 1'b1;
        end else begin
            state         <= state_nx;
            current_floor <= floor_nx;
            pending       <= pending_nx;
            dir_up        <= dir_nx;
            travel_cnt    <= travel_nx;
            move_up       <= (state_nx == UP);
            move_down     <= (state_nx == DOWN);
            motor_stop    <= (state_nx != UP) && (state_nx != DOWN);
        end
    end

`ifdef ELEVATOR_DOOR_DWELL_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) door_cnt <= '0;
        else      door_cnt <= door_nx;
    end
`endif

endmodule

// File: tb/tb_elevator.sv
// Self-checking bench for elevator: directed scenarios followed by random calls
// and emergency stops, checked cycle by cycle against a behavioural model.
module tb_elevator;
    import elevator_pkg::*;

    localparam int T = 1;
    localparam int D = 2;
`ifdef ELEVATOR_DOOR_DWELL_EN
    localparam bit DOOR_EN = 1'b1;
`else
    localparam bit DOOR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  floor_req;
    logic        emergency_stop;
    logic        move_up, move_down, motor_stop;
    floor_t      current_floor;
    state_t      dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // expected {state[2:0], floor[1:0], pending[3:0], up, down, stop}
    logic [11:0] exp_q[$];

    // model state
    state_t   m_state;
    int       m_floor;
    bit [3:0] m_pend;
    bit       m_dir_up;
    int       m_travel;
    int       m_door;

    elevator #(
        .FLOOR_TRAVEL_CYCLES (T),
        .DOOR_DWELL_CYCLES   (D)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .floor_req      (floor_req),
        .emergency_stop (emergency_stop),
        .move_up        (move_up),
        .move_down      (move_down),
        .motor_stop     (motor_stop),
        .current_floor  (current_floor),
        .dbg_state      (dbg_state)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit any_toward(input bit [3:0] p, input int f, input bit up);
        for (int i = 0; i < 4; i++) begin
            if ((up ? (i > f) : (i < f)) && p[i]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_state  = IDLE;
        m_floor  = 0;
        m_pend   = '0;
        m_dir_up = 1'b1;
        m_travel = 0;
        m_door   = 0;
    endtask

    task automatic model_serve(inout bit [3:0] pn);
        pn[m_floor] = 1'b0;
        m_state = DOOR_EN ? DOOR : IDLE;
    endtask

    // one clock edge of the controller, from the rules in plain form
    task automatic model_step(input logic [3:0] req, input logic estop);
        bit [3:0] pn;
        pn = (m_state == ESTOP) ? m_pend : (m_pend | req);
        if (estop) begin
            m_pend   = pn;
            m_state  = ESTOP;
            m_travel = 0;
            m_door   = 0;
        end else begin
            case (m_state)
                ESTOP: m_state = IDLE;
                IDLE: begin
                    if (pn[m_floor]) model_serve(pn);
                    else if (any_toward(pn, m_floor, m_dir_up)) m_state = m_dir_up ? UP : DOWN;
                    else if (any_toward(pn, m_floor, !m_dir_up)) begin
                        m_dir_up = !m_dir_up;
                        m_state  = m_dir_up ? UP : DOWN;
                    end
                    m_pend = pn;
                end
                UP, DOWN: begin
                    m_travel++;
                    if (m_travel == T) begin
                        m_travel = 0;
                        m_floor  = m_floor + ((m_state == UP) ? 1 : -1);
                        if (pn[m_floor]) model_serve(pn);
                        else if (!any_toward(pn, m_floor, m_state == UP)) m_state = IDLE;
                    end
                    m_pend = pn;
                end
                DOOR: begin
                    pn[m_floor] = 1'b0;
                    m_pend = pn;
                    m_door++;
                    if (m_door == D) begin
                        m_door  = 0;
                        m_state = IDLE;
                    end
                end
                default: m_state = IDLE;
            endcase
        end
    endtask

    function automatic logic [11:0] model_outputs();
        logic up, down;
        up   = (m_state == UP);
        down = (m_state == DOWN);
        return {3'(m_state), 2'(m_floor), 4'(m_pend), up, down, !(up || down)};
    endfunction

    // driver: called at a negedge, applies inputs for one edge and checks after it
    task automatic step(input logic [3:0] req, input logic estop);
        logic [11:0] e;
        floor_req      = req;
        emergency_stop = estop;
        model_step(req, estop);
        exp_q.push_back(model_outputs());
        @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check("state",      32'(dbg_state),     32'(e[11:9]));
        check("floor",      32'(current_floor), 32'(e[8:7]));
        check("pending",    32'(dut.pending),   32'(e[6:3]));
        check("move_up",    32'(move_up),       32'(e[2]));
        check("move_down",  32'(move_down),     32'(e[1]));
        check("motor_stop", 32'(motor_stop),    32'(e[0]));
        check("onehot", 32'(move_up) + 32'(move_down) + 32'(motor_stop), 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"},  32'(dbg_state),     32'(IDLE));
        check({tag, "_floor"},  32'(current_floor), 32'd0);
        check({tag, "_pend"},   32'(dut.pending),   32'd0);
        check({tag, "_stop"},   32'(motor_stop),    32'd1);
        check({tag, "_up"},     32'(move_up),       32'd0);
        check({tag, "_down"},   32'(move_down),     32'd0);
    endtask

    initial begin
        int estop_left;
        logic [3:0] req;
        logic es;

        rst            = 1'b0;
        floor_req      = '0;
        emergency_stop = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        rst = 1'b1;

        // idle with no calls
        repeat (10) step(4'b0000, 1'b0);
        check("idle10_floor", 32'(current_floor), 32'd0);

        // floor 0 -> 2
        step(4'b0100, 1'b0);
        check("to2_move_up", 32'(move_up), 32'd1);
        step(4'b0000, 1'b0);
        check("to2_floor1", 32'(current_floor), 32'd1);
        step(4'b0000, 1'b0);
        check("to2_floor2", 32'(current_floor), 32'd2);
        check("to2_stop", 32'(motor_stop), 32'd1);
        repeat (6) step(4'b0000, 1'b0);
        check("to2_pend2", 32'(dut.pending[2]), 32'd0);

        // floor 2 -> 0
        step(4'b0001, 1'b0);
        check("to0_move_down", 32'(move_down), 32'd1);
        repeat (8) step(4'b0000, 1'b0);
        check("to0_floor", 32'(current_floor), 32'd0);

        // floors 1 and 3 in one pulse
        step(4'b1010, 1'b0);
        step(4'b0000, 1'b0);
        check("f13_stop_at1", 32'(current_floor), 32'd1);
        repeat (12) step(4'b0000, 1'b0);
        check("f13_floor3", 32'(current_floor), 32'd3);
        check("f13_pend", 32'(dut.pending), 32'd0);

        // back to 0, then emergency stop on the way to 3
        step(4'b0001, 1'b0);
        repeat (12) step(4'b0000, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        check("es_stop", 32'(motor_stop), 32'd1);
        check("es_floor_held", 32'(current_floor), 32'd1);
        step(4'b0100, 1'b1);
        step(4'b0000, 1'b1);
        check("es_req_ignored", 32'(dut.pending), 32'b1000);
        step(4'b0000, 1'b0);
        check("es_release_idle", 32'(dbg_state), 32'(IDLE));
        step(4'b0000, 1'b0);
        check("es_resume_up", 32'(move_up), 32'd1);
        repeat (6) step(4'b0000, 1'b0);
        check("es_reach3", 32'(current_floor), 32'd3);

        // call for the floor the cab is at
        step(4'b1000, 1'b0);
        check("here_state", 32'(dbg_state), DOOR_EN ? 32'(DOOR) : 32'(IDLE));
        check("here_no_motion", 32'(move_up | move_down), 32'd0);
        check("here_pend", 32'(dut.pending[3]), 32'd0);
        repeat (4) step(4'b0000, 1'b0);

        // random traffic with occasional emergency stops and one asynchronous reset
        estop_left = 0;
        for (int c = 0; c < 2000; c++) begin
            if (c == 1000) begin
                #2 rst = 1'b0;
                #1 check_reset_state("async_rst");
                @(negedge clk);
                rst = 1'b1;
                model_reset();
            end
            req = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
            if (estop_left > 0) begin
                es = 1'b1;
                estop_left--;
            end else if ($urandom_range(0, 60) == 0) begin
                es = 1'b1;
                estop_left = $urandom_range(0, 3);
            end else begin
                es = 1'b0;
            end
            step(req, es);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
